// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the CPU stage-boundary pipeline registers.
// Holds the skid-buffer state encoding and the RV32 NOP used to build bubbles.
// Stage wrappers import this package to construct their BUBBLE parameter.
package pipe_stage_reg_pkg;

  // Occupancy of the two-entry skid buffer; 2'b11 is unused and recovers to EMPTY.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    FULL  = 2'b10
  } pipe_skid_state_t;

  // addi x0, x0, 0 -- canonical RISC-V NOP, the bubble for instruction-carrying stages.
  localparam logic [31:0] RV_NOP_INSN = 32'h0000_0013;

  // The skid stage can take a new beat in every state except FULL.
  function automatic logic skid_accepts(input pipe_skid_state_t st);
    return st != FULL;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register with flush and optional 2-entry skid buffer.
// Latency: 1 cycle from input fire to o_valid when empty; sustains 1 beat/cycle.
// Backpressure: SKID=1 registers o_ready (state != FULL); SKID=0 drives o_ready = ~o_valid | i_ready.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned      WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter bit               SKID   = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  // Handshake events shared by both implementations.
  logic in_fire;
  logic out_fire;

  generate
    if (SKID) begin : g_skid
      // M is always the head of the queue; S only holds a beat while FULL.
      pipe_skid_state_t state_q, state_d;
      logic [WIDTH-1:0] m_q, m_d;
      logic [WIDTH-1:0] s_q, s_d;
      logic             rdy_q;
      logic             head_vld;

      assign head_vld = (state_q == HALF) || (state_q == FULL);
      assign in_fire  = i_valid & rdy_q;
      assign out_fire = head_vld & i_ready;

      // Next-state and datapath: flush wins over any handshake, an illegal encoding falls back to EMPTY.
      always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (i_flush) begin
          state_d = EMPTY;
          m_d     = BUBBLE;
          s_d     = BUBBLE;
        end else begin
          case (state_q)
            EMPTY: begin
              if (in_fire) begin
                m_d     = i_data;
                state_d = HALF;
              end
            end
            HALF: begin
              if (in_fire && out_fire) begin
                m_d = i_data;
              end else if (in_fire) begin
                s_d     = i_data;
                state_d = FULL;
              end else if (out_fire) begin
                state_d = EMPTY;
              end
            end
            FULL: begin
              if (out_fire) begin
                m_d     = s_q;
                state_d = HALF;
              end
            end
            default: begin
              state_d = EMPTY;
              m_d     = BUBBLE;
              s_d     = BUBBLE;
            end
          endcase
        end
      end

      // State, payload and registered ready; ready is low while reset is held.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          state_q <= EMPTY;
          m_q     <= BUBBLE;
          s_q     <= BUBBLE;
          rdy_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          m_q     <= m_d;
          s_q     <= s_d;
          rdy_q   <= skid_accepts(state_d);
        end
      end

      assign o_ready = rdy_q;
      assign o_valid = head_vld;
      assign o_data  = head_vld ? m_q : BUBBLE;

    end else begin : g_single
      // Single register; ready looks through to downstream so a stalled full stage refills on drain.
      logic             v_q, v_d;
      logic [WIDTH-1:0] m_q, m_d;
      logic             rdy;

      assign rdy      = i_rst_n & (~v_q | i_ready);
      assign in_fire  = i_valid & rdy;
      assign out_fire = v_q & i_ready;

      // Next-state: flush drops everything, a new beat replaces the head, a lone drain empties.
      always_comb begin
        v_d = v_q;
        m_d = m_q;
        if (i_flush) begin
          v_d = 1'b0;
          m_d = BUBBLE;
        end else if (in_fire) begin
          v_d = 1'b1;
          m_d = i_data;
        end else if (out_fire) begin
          v_d = 1'b0;
        end
      end

      // Valid flag and payload register.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          v_q <= 1'b0;
          m_q <= BUBBLE;
        end else begin
          v_q <= v_d;
          m_q <= m_d;
        end
      end

      assign o_ready = rdy;
      assign o_valid = v_q;
      assign o_data  = v_q ? m_q : BUBBLE;
    end
  endgenerate

endmodule
